// File: rtl/shoot_target_selector.sv
// -----------------------------------------------------------------------------
// shoot_target_selector
//
// N-player shoot-target selector. The current shooter arms a target with a
// select key, may retarget or cancel, and fires with the trigger. A fired
// shot is presented as a registered record (target index, self-shot flag)
// that is held until the round controller acknowledges it. While armed, the
// chosen target's highlight LED blinks. An optional arm timeout disarms the
// selector after ARM_TIMEOUT quiet cycles.
//
// Build option:
//   SHOOT_BLINK_EN  - when defined, the blink phase comes from an internal
//                     BLINK_DIV-bit counter restarted on every arming, so the
//                     LED is lit in the first half-period after arming. When
//                     undefined, the blink phase is taken from i_sparkle.
//
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_shooter      index of the player whose turn it is
//   i_sel          one-hot-ish target select request, lowest set bit wins
//   i_trigger      fire request (acts only while armed)
//   i_cancel       disarm request (acts only while armed, beats trigger)
//   i_sparkle      external blink phase (unused with SHOOT_BLINK_EN)
//   i_shot_ack     consumer accepts the shot record
//   o_hilite       blinking highlight of the armed target
//   o_armed        high while armed
//   o_shot_valid   shot record valid
//   o_shot_target  target of the shot
//   o_shot_self    shot target equals the shooter at trigger time
//   o_timeout      one-cycle pulse when the armed state expires
// -----------------------------------------------------------------------------
module shoot_target_selector #(
    parameter int N_PLAYERS   = 4,
    parameter int IDX_W       = 2,
    parameter int ARM_TIMEOUT = 0,
    parameter int BLINK_DIV   = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [IDX_W-1:0]     i_shooter,
    input  logic [N_PLAYERS-1:0] i_sel,
    input  logic                 i_trigger,
    input  logic                 i_cancel,
    input  logic                 i_sparkle,
    input  logic                 i_shot_ack,
    output logic [N_PLAYERS-1:0] o_hilite,
    output logic                 o_armed,
    output logic                 o_shot_valid,
    output logic [IDX_W-1:0]     o_shot_target,
    output logic                 o_shot_self,
    output logic                 o_timeout
);

    // Timer only needs to reach ARM_TIMEOUT-1; keep at least one bit so the
    // timeout-disabled build still has a legal vector.
    localparam int TMR_W = (ARM_TIMEOUT > 0) ? $clog2(ARM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   target_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [IDX_W-1:0]   shot_target_reg;
    logic               shot_self_reg;
    logic               timeout_reg;

    logic               sel_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic               timer_expired;
    logic               arm_entry;
    logic               blink;

    // Lowest set bit wins: scan from the top so lower indices overwrite.
    always_comb begin
        sel_idx = '0;
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (i_sel[k]) begin
                sel_idx = IDX_W'(k);
            end
        end
    end

    assign sel_hit   = |i_sel;
    assign arm_entry = (state_reg == ST_IDLE) && sel_hit;

    generate
        if (ARM_TIMEOUT != 0) begin : g_timeout
            assign timer_expired = (timer_reg == TMR_W'(ARM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timer_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= ST_IDLE;
            target_reg      <= '0;
            timer_reg       <= '0;
            shot_target_reg <= '0;
            shot_self_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (sel_hit) begin
                        state_reg  <= ST_ARMED;
                        target_reg <= sel_idx;
                        timer_reg  <= '0;
                    end
                end
                ST_ARMED: begin
                    if (i_cancel) begin
                        state_reg <= ST_IDLE;
                    end else if (i_trigger) begin
                        // Shooter is sampled only here; later changes do not
                        // affect the held record.
                        state_reg       <= ST_FIRE;
                        shot_target_reg <= target_reg;
                        shot_self_reg   <= (target_reg == i_shooter);
                    end else if (timer_expired) begin
                        state_reg   <= ST_IDLE;
                        timeout_reg <= 1'b1;
                    end else if (sel_hit) begin
                        target_reg <= sel_idx;
                        timer_reg  <= '0;
                    end else if (ARM_TIMEOUT != 0) begin
                        // Never wraps: expiry fires at ARM_TIMEOUT-1.
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                ST_FIRE: begin
                    if (i_shot_ack) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHOOT_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt_reg;
    logic                 unused_sparkle;

    assign unused_sparkle = i_sparkle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_reg <= '0;
        end else if (arm_entry) begin
            blink_cnt_reg <= '0;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_DIV'(1);
        end
    end

    // Lit during the first half-period after arming.
    assign blink = ~blink_cnt_reg[BLINK_DIV-1];
`else
    logic unused_arm_entry;

    assign unused_arm_entry = arm_entry;
    assign blink            = i_sparkle;
`endif

    assign o_armed       = (state_reg == ST_ARMED);
    assign o_shot_valid  = (state_reg == ST_FIRE);
    assign o_shot_target = shot_target_reg;
    assign o_shot_self   = shot_self_reg;
    assign o_timeout     = timeout_reg;

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_hilite
            assign o_hilite[gi] = o_armed & (target_reg == IDX_W'(gi)) & blink;
        end
    endgenerate

endmodule

// File: tb/tb_shoot_target_selector.sv
// -----------------------------------------------------------------------------
// tb_shoot_target_selector
//
// Scoreboard bench for shoot_target_selector (default build, blink phase from
// i_sparkle, ARM_TIMEOUT = 8). A driver applies one input vector per cycle on
// the falling edge, advances a behavioural model of the game rules and pushes
// the expected post-edge outputs into a queue. A monitor pops and compares one
// entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_shoot_target_selector;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] shooter = '0;
    logic [NP-1:0] sel = '0;
    logic          trigger = 1'b0;
    logic          cancel = 1'b0;
    logic          sparkle = 1'b0;
    logic          shot_ack = 1'b0;
    logic [NP-1:0] hilite;
    logic          armed;
    logic          shot_valid;
    logic [IW-1:0] shot_target;
    logic          shot_self;
    logic          timeout;

    always #5 clk = ~clk;

    shoot_target_selector #(
        .N_PLAYERS   (NP),
        .IDX_W       (IW),
        .ARM_TIMEOUT (TO),
        .BLINK_DIV   (24)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_shooter     (shooter),
        .i_sel         (sel),
        .i_trigger     (trigger),
        .i_cancel      (cancel),
        .i_sparkle     (sparkle),
        .i_shot_ack    (shot_ack),
        .o_hilite      (hilite),
        .o_armed       (armed),
        .o_shot_valid  (shot_valid),
        .o_shot_target (shot_target),
        .o_shot_self   (shot_self),
        .o_timeout     (timeout)
    );

    typedef struct packed {
        logic [NP-1:0] hilite;
        logic          armed;
        logic          valid;
        logic [IW-1:0] tgt;
        logic          self_shot;
        logic          tmo;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;

    // Behavioural model of the game rules.
    bit   m_armed;
    bit   m_firing;
    int   m_target;
    int   m_quiet;      // consecutive armed edges without select/trigger/cancel
    int   m_shot_tgt;
    bit   m_shot_self;

    function automatic void model_reset();
        m_armed     = 0;
        m_firing    = 0;
        m_target    = 0;
        m_quiet     = 0;
        m_shot_tgt  = 0;
        m_shot_self = 0;
    endfunction

    // Advance the model by one clock edge and return the outputs seen after it.
    function automatic obs_t model_step(logic [NP-1:0] s, logic trg, logic cnc,
                                        logic ack, int shoot, logic spk, logic rv);
        obs_t e;
        int   idx = -1;
        bit   tmo = 0;
        for (int k = 0; k < NP; k++) begin
            if (s[k] && idx < 0) idx = k;
        end
        if (!rv) begin
            model_reset();
        end else if (m_firing) begin
            if (ack) m_firing = 0;
        end else if (m_armed) begin
            if (cnc) begin
                m_armed = 0;
            end else if (trg) begin
                m_armed     = 0;
                m_firing    = 1;
                m_shot_tgt  = m_target;
                m_shot_self = (m_target == shoot);
            end else if (m_quiet + 1 == TO) begin
                m_armed = 0;
                tmo     = 1;
            end else if (idx >= 0) begin
                m_target = idx;
                m_quiet  = 0;
            end else begin
                m_quiet++;
            end
        end else if (idx >= 0) begin
            m_armed  = 1;
            m_target = idx;
            m_quiet  = 0;
        end
        e.hilite    = (m_armed && spk) ? NP'(1 << m_target) : '0;
        e.armed     = m_armed;
        e.valid     = m_firing;
        e.tgt       = m_firing ? IW'(m_shot_tgt) : '0;
        e.self_shot = m_firing ? m_shot_self : 1'b0;
        e.tmo       = tmo;
        return e;
    endfunction

    task automatic cycle(input logic [NP-1:0] s, input logic trg, input logic cnc,
                         input logic ack, input logic [IW-1:0] shoot,
                         input logic spk, input logic rv);
        @(negedge clk);
        rst_n    = rv;
        sel      = s;
        trigger  = trg;
        cancel   = cnc;
        shot_ack = ack;
        shooter  = shoot;
        sparkle  = spk;
        exp_q.push_back(model_step(s, trg, cnc, ack, int'(shoot), spk, rv));
    endtask

    task automatic quiet(input int n, input logic spk);
        for (int i = 0; i < n; i++) cycle('0, 0, 0, 0, '0, spk, 1);
    endtask

    task automatic check_now(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end else begin
            $display("check %s ok value=%0d", name, act);
        end
    endtask

    // Monitor: one comparison per clock edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.hilite    = hilite;
                a.armed     = armed;
                a.valid     = shot_valid;
                a.tgt       = shot_valid ? shot_target : '0;
                a.self_shot = shot_valid ? shot_self : 1'b0;
                a.tmo       = timeout;
                n_checks++;
                txn++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs txn=%0d actual hil=%b arm=%b vld=%b tgt=%0d self=%b tmo=%b required hil=%b arm=%b vld=%b tgt=%0d self=%b tmo=%b",
                             txn, a.hilite, a.armed, a.valid, a.tgt, a.self_shot, a.tmo,
                             e.hilite, e.armed, e.valid, e.tgt, e.self_shot, e.tmo);
                end else begin
                    $display("txn %0d hil=%b arm=%b vld=%b tgt=%0d self=%b tmo=%b",
                             txn, a.hilite, a.armed, a.valid, a.tgt, a.self_shot, a.tmo);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset held for a few edges: all outputs zero.
        cycle(4'b0100, 1, 1, 1, 2'd1, 1, 0);
        cycle(4'b1111, 1, 0, 0, 2'd3, 1, 0);

        // Arm on 2, highlight follows the blink phase.
        cycle(4'b0100, 0, 0, 0, 2'd0, 1, 1);
        cycle('0, 0, 0, 0, 2'd0, 1, 1);
        cycle('0, 0, 0, 0, 2'd0, 0, 1);
        cycle('0, 0, 0, 0, 2'd0, 1, 1);

        // Retarget with two bits set (lowest wins), then self-shot.
        cycle(4'b1010, 0, 0, 0, 2'd0, 1, 1);
        cycle(4'b1000, 1, 0, 0, 2'd1, 1, 1);

        // FIRE held five cycles while other inputs toggle, then ack.
        for (int i = 0; i < 5; i++) begin
            cycle(4'($urandom), 1'($urandom), 1'($urandom), 0, 2'($urandom), 1, 1);
        end
        cycle('0, 0, 0, 1, 2'd0, 1, 1);
        quiet(1, 1);

        // Non-self shot with ack in the first FIRE cycle.
        cycle(4'b0001, 0, 0, 0, 2'd0, 1, 1);
        cycle('0, 1, 0, 0, 2'd3, 1, 1);
        cycle('0, 0, 0, 1, 2'd0, 1, 1);
        quiet(1, 1);

        // Trigger + cancel together: cancel wins. Trigger/cancel in IDLE ignored.
        cycle(4'b0010, 0, 0, 0, 2'd0, 1, 1);
        cycle('0, 1, 1, 0, 2'd1, 1, 1);
        cycle('0, 1, 0, 0, 2'd1, 1, 1);
        cycle('0, 0, 1, 1, 2'd1, 1, 1);

        // Timeout with no activity, then with a restart at cycle 5.
        cycle(4'b1000, 0, 0, 0, 2'd0, 1, 1);
        quiet(10, 1);
        cycle(4'b0001, 0, 0, 0, 2'd0, 1, 1);
        quiet(4, 1);
        cycle(4'b0100, 0, 0, 0, 2'd0, 1, 1);
        quiet(10, 1);

        // Reset in the middle of FIRE drops everything at once.
        cycle(4'b0100, 0, 0, 0, 2'd0, 1, 1);
        cycle('0, 1, 0, 0, 2'd2, 1, 1);
        cycle('0, 0, 0, 0, 2'd2, 1, 0);
        #1;
        check_now("async_rst_valid", int'(shot_valid), 0);
        check_now("async_rst_armed", int'(armed), 0);
        check_now("async_rst_hilite", int'(hilite), 0);
        cycle('0, 0, 0, 0, 2'd0, 1, 0);
        quiet(3, 1);
        cycle(4'b0001, 0, 0, 0, 2'd0, 1, 1);
        quiet(2, 1);

        // Randomized play.
        for (int i = 0; i < 600; i++) begin
            logic [NP-1:0] s;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            cycle(s,
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) == 0),
                  2'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 199) != 0));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
